key_mode_ctrl: RTL and testbench

//  Front end for the PWM mode selector on DE0-Nano. Takes the two raw active-low

---
 rtl/key_mode_ctrl_pkg.sv | 17 +
 rtl/key_mode_ctrl_if.sv | 19 +
 rtl/key_mode_ctrl_debounce.sv | 53 +++++
 rtl/key_mode_ctrl.sv | 76 +++++++
 tb/tb_key_mode_ctrl.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/key_mode_ctrl_pkg.sv
// Mode constants shared with the PWM stage, plus the mode-selector state type.
package pwm_pkg;
    localparam logic [1:0] MODE_OFF = 2'b00;
    localparam logic [1:0] MODE_A   = 2'b01;
    localparam logic [1:0] MODE_B   = 2'b10;
endpackage

package key_mode_ctrl_pkg;
    import pwm_pkg::*;

    // State encoding is the sel encoding, so sel is the state register itself.
    typedef enum logic [1:0] {
        ST_OFF = MODE_OFF,
        ST_A   = MODE_A,
        ST_B   = MODE_B
    } mode_state_e;
endpackage

// File: rtl/key_mode_ctrl_if.sv
// Key inputs and mode-select outputs of the PWM mode front end.
interface key_mode_ctrl_if;
    logic       key0_n;
    logic       key1_n;
    logic [1:0] sel;
    logic       sel_chg;
    logic       key0_db;
    logic       key1_db;

    modport master (
        output key0_n, key1_n,
        input  sel, sel_chg, key0_db, key1_db
    );

    modport slave (
        input  key0_n, key1_n,
        output sel, sel_chg, key0_db, key1_db
    );
endinterface

// File: rtl/key_mode_ctrl_debounce.sv
// One pushbutton: synchroniser, hold-time debouncer and press-edge pulse.
module key_debounce #(
    parameter int DB_CYCLES   = 1_000_000,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic level,
    output logic press
);
    localparam int            CW       = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_r;
    logic [CW-1:0]          cnt_r;
    logic                   pressed_r;
    logic                   press_r;
    logic                   synced_pressed_s;

    assign synced_pressed_s = ~sync_r[SYNC_STAGES-1];

    // Synchroniser shift register, preset to the released level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= {SYNC_STAGES{1'b1}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], key_n};
        end
    end

    // Hold counter: a differing level must persist unbroken before it is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r     <= {CW{1'b0}};
            pressed_r <= 1'b0;
            press_r   <= 1'b0;
        end else if (synced_pressed_s == pressed_r) begin
            cnt_r   <= {CW{1'b0}};
            press_r <= 1'b0;
        end else if (cnt_r == CNT_LAST) begin
            cnt_r     <= {CW{1'b0}};
            pressed_r <= synced_pressed_s;
            press_r   <= synced_pressed_s;
        end else begin
            cnt_r   <= cnt_r + CW'(1);
            press_r <= 1'b0;
        end
    end

    assign level = pressed_r;
    assign press = press_r;
endmodule

// File: rtl/key_mode_ctrl.sv
// Two debounced pushbuttons drive a latched one-hot PWM mode select.
module key_mode_ctrl
    import key_mode_ctrl_pkg::*;
#(
    parameter int DB_CYCLES   = 1_000_000,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst,
    key_mode_ctrl_if.slave  bus
);
    logic        level0_s;
    logic        level1_s;
    logic        press0_s;
    logic        press1_s;
    mode_state_e state_r;
    mode_state_e state_s;
    logic        chg_r;
    logic        chg_s;

    key_debounce #(
        .DB_CYCLES   (DB_CYCLES),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_key0 (
        .clk   (clk),
        .rst   (rst),
        .key_n (bus.key0_n),
        .level (level0_s),
        .press (press0_s)
    );

    key_debounce #(
        .DB_CYCLES   (DB_CYCLES),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_key1 (
        .clk   (clk),
        .rst   (rst),
        .key_n (bus.key1_n),
        .level (level1_s),
        .press (press1_s)
    );

    // Next mode: a lone press selects its mode, or turns it off if already active.
    always_comb begin
        state_s = state_r;
        chg_s   = 1'b0;
        if (press0_s ^ press1_s) begin
            chg_s = 1'b1;
            case (state_r)
                ST_OFF:  state_s = press0_s ? ST_A   : ST_B;
                ST_A:    state_s = press0_s ? ST_OFF : ST_B;
                ST_B:    state_s = press0_s ? ST_A   : ST_OFF;
                default: state_s = ST_OFF;
            endcase
        end else begin
            state_s = state_r;
            chg_s   = 1'b0;
        end
    end

    // Mode register and change strobe update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_OFF;
            chg_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            chg_r   <= chg_s;
        end
    end

    assign bus.sel     = state_r;
    assign bus.sel_chg = chg_r;
    assign bus.key0_db = level0_s;
    assign bus.key1_db = level1_s;
endmodule

// File: tb/tb_key_mode_ctrl.sv
// Directed vector table plus random key activity against a window-based reference model.
module tb_key_mode_ctrl;
    localparam int DB = 8;
    localparam int SY = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    key_mode_ctrl_if bus ();

    key_mode_ctrl #(.DB_CYCLES(DB), .SYNC_STAGES(SY)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    int chg_seen;

    // Reference model: raw samples flow through a delay line; a key's accepted
    // level flips once the last DB delayed samples all disagree with it.
    bit         pipe [2][$];
    bit         win  [2][$];
    bit         m_pr [2];
    bit         m_pend [2];
    logic [1:0] m_sel;
    bit         m_chg;

    typedef struct {
        bit         r;
        bit         k0;
        bit         k1;
        int         n;
        logic [1:0] sel;
        bit         chg;
        bit         db0;
        bit         db1;
        int         pulses;
    } vec_t;
    vec_t vt [$];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(bit r, bit k0, bit k1);
        bit         kn [2];
        bit         seen;
        bit         all_diff;
        logic [1:0] tgt;
        kn[0] = k0;
        kn[1] = k1;
        if (r) begin
            for (int i = 0; i < 2; i++) begin
                pipe[i].delete();
                for (int j = 0; j < SY; j++) pipe[i].push_back(1'b1);
                win[i].delete();
                m_pr[i]   = 1'b0;
                m_pend[i] = 1'b0;
            end
            m_sel = 2'b00;
            m_chg = 1'b0;
        end else begin
            m_chg = 1'b0;
            if (m_pend[0] != m_pend[1]) begin
                tgt   = m_pend[0] ? 2'b01 : 2'b10;
                m_sel = (m_sel == tgt) ? 2'b00 : tgt;
                m_chg = 1'b1;
            end
            for (int i = 0; i < 2; i++) begin
                seen = pipe[i].pop_front();
                pipe[i].push_back(kn[i]);
                win[i].push_back(seen);
                if (win[i].size() > DB) void'(win[i].pop_front());
                m_pend[i] = 1'b0;
                if (win[i].size() == DB) begin
                    all_diff = 1'b1;
                    for (int j = 0; j < win[i].size(); j++)
                        if (win[i][j] != m_pr[i]) all_diff = 1'b0;
                    if (all_diff) begin
                        m_pr[i]   = !m_pr[i];
                        m_pend[i] = m_pr[i];
                    end
                end
            end
        end
    endtask

    task automatic step(bit r, bit k0, bit k1);
        rst        = r;
        bus.key0_n = k0;
        bus.key1_n = k1;
        @(posedge clk);
        model_edge(r, k0, k1);
        #1;
        check("model sel",     32'(bus.sel),     32'(m_sel));
        check("model sel_chg", 32'(bus.sel_chg), 32'(m_chg));
        check("model key0_db", 32'(bus.key0_db), 32'(m_pr[0]));
        check("model key1_db", 32'(bus.key1_db), 32'(m_pr[1]));
        if (bus.sel_chg) chg_seen++;
    endtask

    function automatic void add(bit r, bit k0, bit k1, int n, logic [1:0] s,
                                bit c, bit d0, bit d1, int p);
        vec_t v;
        v.r = r; v.k0 = k0; v.k1 = k1; v.n = n;
        v.sel = s; v.chg = c; v.db0 = d0; v.db1 = d1; v.pulses = p;
        vt.push_back(v);
    endfunction

    initial begin
        int seg_len;
        bit r;
        bit k0;
        bit k1;
        rst        = 1'b1;
        bus.key0_n = 1'b1;
        bus.key1_n = 1'b1;

        //   rst k0 k1  n   sel    chg db0 db1 pulses
        add(1, 1, 1,   3, 2'b00, 0, 0, 0, 0);   // reset, keys released
        add(0, 1, 1, 100, 2'b00, 0, 0, 0, 0);   // idle, no change
        add(0, 0, 1,  10, 2'b00, 0, 1, 0, 0);   // key0 accepted, sel not yet
        add(0, 0, 1,   1, 2'b01, 1, 1, 0, 1);   // 11th edge: MODE_A
        add(0, 0, 1,   1, 2'b01, 0, 1, 0, 0);
        add(0, 0, 1,  10, 2'b01, 0, 1, 0, 0);
        add(0, 1, 1,  20, 2'b01, 0, 0, 0, 0);   // release: no event
        add(0, 0, 1,   3, 2'b01, 0, 0, 0, 0);   // bounce 0,1,0,1
        add(0, 1, 1,   3, 2'b01, 0, 0, 0, 0);
        add(0, 0, 1,   3, 2'b01, 0, 0, 0, 0);
        add(0, 1, 1,   3, 2'b01, 0, 0, 0, 0);
        add(0, 0, 1,  10, 2'b01, 0, 1, 0, 0);   // final edge, hold
        add(0, 0, 1,   1, 2'b00, 1, 1, 0, 1);   // active key turns it off
        add(0, 1, 1,  20, 2'b00, 0, 0, 0, 0);
        add(0, 0, 1,   5, 2'b00, 0, 0, 0, 0);   // 5-cycle glitch
        add(0, 1, 1,  20, 2'b00, 0, 0, 0, 0);
        add(0, 0, 1,  15, 2'b01, 0, 1, 0, 1);   // to MODE_A
        add(0, 1, 1,  15, 2'b01, 0, 0, 0, 0);
        add(0, 1, 0,  15, 2'b10, 0, 0, 1, 1);   // key1 -> MODE_B
        add(0, 1, 1,  15, 2'b10, 0, 0, 0, 0);
        add(0, 1, 0,  15, 2'b00, 0, 0, 1, 1);   // key1 again -> OFF
        add(0, 1, 1,  15, 2'b00, 0, 0, 0, 0);
        add(0, 0, 0,  20, 2'b00, 0, 1, 1, 0);   // simultaneous presses
        add(0, 1, 1,  20, 2'b00, 0, 0, 0, 0);
        add(0, 1, 0,  15, 2'b10, 0, 0, 1, 1);   // to MODE_B
        add(0, 1, 1,  15, 2'b10, 0, 0, 0, 0);
        add(0, 0, 1,   4, 2'b10, 0, 0, 0, 0);   // 4 cycles into key0 debounce
        add(1, 0, 1,   1, 2'b00, 0, 0, 0, 0);   // reset mid-debounce, mid-mode
        add(0, 0, 1,  10, 2'b00, 0, 1, 0, 0);   // full debounce restarts
        add(0, 0, 1,   1, 2'b01, 1, 1, 0, 1);
        add(0, 1, 1,  15, 2'b01, 0, 0, 0, 0);

        foreach (vt[i]) begin
            chg_seen = 0;
            for (int c = 0; c < vt[i].n; c++) step(vt[i].r, vt[i].k0, vt[i].k1);
            check($sformatf("row%0d sel", i),     32'(bus.sel),     32'(vt[i].sel));
            check($sformatf("row%0d sel_chg", i), 32'(bus.sel_chg), 32'(vt[i].chg));
            check($sformatf("row%0d key0_db", i), 32'(bus.key0_db), 32'(vt[i].db0));
            check($sformatf("row%0d key1_db", i), 32'(bus.key1_db), 32'(vt[i].db1));
            check($sformatf("row%0d pulses", i),  32'(chg_seen),    32'(vt[i].pulses));
        end

        for (int s = 0; s < 200; s++) begin
            r       = ($urandom_range(0, 39) == 0);
            k0      = 1'($urandom_range(0, 1));
            k1      = 1'($urandom_range(0, 1));
            seg_len = r ? int'($urandom_range(1, 3)) : int'($urandom_range(1, 14));
            for (int c = 0; c < seg_len; c++) step(r, k0, k1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
